// File: rtl/card_shoe.sv
// Card-draw responder: deals pseudo-random cards without replacement from a DECKS x 52 shoe.
// Latency: 2..31 cycles from an accepted req to the card_valid pulse.
// Backpressure: req is taken only while req_ready=1; shuffle aborts any draw and restocks.
module card_shoe #(
    parameter int          DECKS = 1,
    parameter logic [15:0] SEED  = 16'hACE1,
    localparam int         CW    = $clog2(52 * DECKS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          shuffle,
    output logic          req_ready,
    output logic          card_valid,
    output logic [3:0]    card_rank,
    output logic [3:0]    card_value,
    output logic [15:0]   card_ascii,
    output logic [CW-1:0] cards_left,
    output logic          empty,
    output logic          err
);

    localparam int          NW       = $clog2(4 * DECKS + 1);
    localparam logic [NW-1:0] FULL   = NW'(4 * DECKS);
    localparam logic [CW-1:0] TOTAL  = CW'(52 * DECKS);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PICK    = 2'd1,
        SCAN    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [3:0]      tries, tries_nxt;
    logic [3:0]      ptr, ptr_nxt;
    logic [3:0]      rank, rank_nxt;
    logic [NW-1:0]   count [13];
    logic [CW-1:0]   left_q;
    logic            err_q, err_nxt;
    logic            restock, deliver;
    logic [15:0]     stocked;
    logic [3:0]      cand;
    logic [3:0]      last_rank, last_value;
    logic [15:0]     last_ascii;

    // Blackjack point value of a rank.
    function automatic logic [3:0] value_of(input logic [3:0] r);
        if (r == 4'd0)
            return 4'd11;
        else if (r <= 4'd9)
            return r + 4'd1;
        else
            return 4'd10;
    endfunction

    // Right-justified ASCII label of a rank.
    function automatic logic [15:0] ascii_of(input logic [3:0] r);
        case (r)
            4'd0:    return 16'h0041;
            4'd9:    return 16'h3130;
            4'd10:   return 16'h004A;
            4'd11:   return 16'h0051;
            4'd12:   return 16'h004B;
            default: return {8'h00, 8'h31 + {4'h0, r}};
        endcase
    endfunction

    // Per-rank "has stock" flags padded to 16 so any 4-bit candidate indexes safely.
    always_comb begin
        stocked = 16'h0000;
        for (int i = 0; i < 13; i++) begin
            stocked[i] = (count[i] != '0);
        end
    end

    assign cand = lfsr[3:0];

    // Galois LFSR free-runs in every state so request timing feeds the draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED_EFF;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Next-state and draw control; shuffle overrides every state.
    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        ptr_nxt   = ptr;
        rank_nxt  = rank;
        restock   = 1'b0;
        deliver   = 1'b0;
        err_nxt   = 1'b0;
        if (shuffle) begin
            restock   = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (left_q == '0) begin
                            err_nxt = 1'b1;
                        end else begin
                            state_nxt = PICK;
                            tries_nxt = 4'd0;
                        end
                    end
                end
                PICK: begin
                    if (stocked[cand]) begin
                        rank_nxt  = cand;
                        state_nxt = DELIVER;
                    end else if (tries == 4'd15) begin
                        // Random tries exhausted: fall back to a deterministic walk.
                        ptr_nxt   = (cand >= 4'd13) ? cand - 4'd13 : cand;
                        state_nxt = SCAN;
                    end else begin
                        tries_nxt = tries + 4'd1;
                    end
                end
                SCAN: begin
                    if (stocked[ptr]) begin
                        rank_nxt  = ptr;
                        state_nxt = DELIVER;
                    end else begin
                        ptr_nxt = (ptr == 4'd12) ? 4'd0 : ptr + 4'd1;
                    end
                end
                DELIVER: begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, draw bookkeeping and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tries <= 4'd0;
            ptr   <= 4'd0;
            rank  <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            tries <= tries_nxt;
            ptr   <= ptr_nxt;
            rank  <= rank_nxt;
            err_q <= err_nxt;
        end
    end

    // Shoe stock: restock on shuffle, decrement the dealt rank on delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 13; i++) begin
                count[i] <= FULL;
            end
            left_q <= TOTAL;
        end else if (restock) begin
            for (int i = 0; i < 13; i++) begin
                count[i] <= FULL;
            end
            left_q <= TOTAL;
        end else if (deliver) begin
            for (int i = 0; i < 13; i++) begin
                if (rank == 4'(i) && count[i] != '0)
                    count[i] <= count[i] - NW'(1);
            end
            if (left_q != '0)
                left_q <= left_q - CW'(1);
        end
    end

    // Remember the last delivered card so card_* hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rank  <= 4'd0;
            last_value <= 4'd0;
            last_ascii <= 16'h0000;
        end else if (deliver) begin
            last_rank  <= rank;
            last_value <= value_of(rank);
            last_ascii <= ascii_of(rank);
        end
    end

    assign req_ready  = (state == IDLE);
    assign card_valid = deliver;
    assign card_rank  = deliver ? rank : last_rank;
    assign card_value = deliver ? value_of(rank) : last_value;
    assign card_ascii = deliver ? ascii_of(rank) : last_ascii;
    assign cards_left = left_q;
    assign empty      = (left_q == '0);
    assign err        = err_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: full-deck deal, empty error, shuffle abort, async reset, replay.
// Latency: each draw is bounded to 40 cycles; the whole run is a few hundred cycles.
// Backpressure: requests are issued only while req_ready=1 and dropped after acceptance.
module tb_card_shoe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        shuffle;
    logic        req_ready;
    logic        card_valid;
    logic [3:0]  card_rank;
    logic [3:0]  card_value;
    logic [15:0] card_ascii;
    logic [5:0]  cards_left;
    logic        empty;
    logic        err;

    card_shoe #(.DECKS(1), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .shuffle    (shuffle),
        .req_ready  (req_ready),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_value (card_value),
        .card_ascii (card_ascii),
        .cards_left (cards_left),
        .empty      (empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rank;
        logic [3:0]  value;
        logic [15:0] ascii;
    } vec_t;

    vec_t       tbl [13];
    int         hist [13];
    logic [3:0] seq1 [52];
    logic [3:0] seen_value [13];
    logic [15:0] seen_ascii [13];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full request/response handshake; idx is the number of cards already dealt.
    task automatic draw(input int gap, input int idx, output logic [3:0] r);
        int k;
        bit got;
        r = 4'hF;
        repeat (gap) @(negedge clk);
        check("ready_before_req", req_ready, 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        k = 1;
        got = 1'b0;
        while (k <= 40 && !got) begin
            if (card_valid) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("card_timeout", got, 1);
        if (got) begin
            check("latency_min", k >= 2, 1);
            check("latency_max", k <= 31, 1);
            r = card_rank;
            check("rank_range", r <= 4'd12, 1);
            if (r <= 4'd12) begin
                check("card_value", card_value, tbl[r].value);
                check("card_ascii", card_ascii, tbl[r].ascii);
                check("rank_in_stock", hist[r] < 4, 1);
                hist[r]++;
                seen_value[r] = card_value;
                seen_ascii[r] = card_ascii;
            end
            check("left_at_pulse", cards_left, 52 - idx);
            @(negedge clk);
            check("pulse_one_cycle", card_valid, 0);
            check("left_after", cards_left, 51 - idx);
            check("ready_after", req_ready, 1);
            check("hold_rank", card_rank, r);
        end
    endtask

    // Deal the whole deck with a fixed request timing pattern.
    task automatic run_deck(input bit replay);
        logic [3:0] r;
        for (int i = 0; i < 13; i++) hist[i] = 0;
        for (int i = 0; i < 52; i++) begin
            draw(i % 3, i, r);
            if (replay) check("replay_seq", r, seq1[i]);
            else seq1[i] = r;
        end
        check("empty_after_deck", empty, 1);
        check("left_zero", cards_left, 0);
        for (int i = 0; i < 13; i++) begin
            check("rank_hist", hist[i], 4);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ready", req_ready, 1);
        check("rst_valid", card_valid, 0);
        check("rst_err", err, 0);
        check("rst_rank", card_rank, 0);
        check("rst_value", card_value, 0);
        check("rst_ascii", card_ascii, 0);
        check("rst_left", cards_left, 52);
        check("rst_empty", empty, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        int cv_seen;

        tbl[0]  = '{4'd0,  4'd11, 16'h0041};
        tbl[1]  = '{4'd1,  4'd2,  16'h0032};
        tbl[2]  = '{4'd2,  4'd3,  16'h0033};
        tbl[3]  = '{4'd3,  4'd4,  16'h0034};
        tbl[4]  = '{4'd4,  4'd5,  16'h0035};
        tbl[5]  = '{4'd5,  4'd6,  16'h0036};
        tbl[6]  = '{4'd6,  4'd7,  16'h0037};
        tbl[7]  = '{4'd7,  4'd8,  16'h0038};
        tbl[8]  = '{4'd8,  4'd9,  16'h0039};
        tbl[9]  = '{4'd9,  4'd10, 16'h3130};
        tbl[10] = '{4'd10, 4'd10, 16'h004A};
        tbl[11] = '{4'd11, 4'd10, 16'h0051};
        tbl[12] = '{4'd12, 4'd10, 16'h004B};
        for (int i = 0; i < 13; i++) begin
            seen_value[i] = 4'hF;
            seen_ascii[i] = 16'hFFFF;
        end

        rst_n   = 1'b0;
        req     = 1'b0;
        shuffle = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Full deck from reset; record the sequence for the replay later.
        run_deck(1'b0);

        // Table sweep: every rank dealt, with its labelled value and ASCII text.
        for (int i = 0; i < 13; i++) begin
            check("tbl_value", seen_value[tbl[i].rank], tbl[i].value);
            check("tbl_ascii", seen_ascii[tbl[i].rank], tbl[i].ascii);
        end

        // Request while empty: one-cycle err, no card, stock unchanged.
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("err_pulse", err, 1);
        check("err_no_card", card_valid, 0);
        check("err_left", cards_left, 0);
        check("err_hold_rank", card_rank, seq1[51]);
        @(negedge clk);
        check("err_clears", err, 0);
        check("err_no_card2", card_valid, 0);
        check("err_ready", req_ready, 1);

        // Shuffle from IDLE restocks the shoe.
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        check("shuffle_left", cards_left, 52);
        check("shuffle_empty", empty, 0);

        for (int i = 0; i < 13; i++) hist[i] = 0;
        draw(0, 0, r);

        // Shuffle during PICK aborts the draw and restocks.
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        shuffle = 1'b1;
        check("pick_no_card", card_valid, 0);
        @(negedge clk);
        shuffle = 1'b0;
        check("abort_no_card", card_valid, 0);
        check("abort_left", cards_left, 52);
        check("abort_ready", req_ready, 1);
        cv_seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (card_valid) cv_seen++;
        end
        check("abort_stays_quiet", cv_seen, 0);

        // Async reset in the middle of a draw.
        for (int i = 0; i < 13; i++) hist[i] = 0;
        draw(0, 0, r);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        cv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (card_valid) cv_seen++;
        end
        check("rst_no_card", cv_seen, 0);
        rst_n = 1'b1;

        // Same seed and request timing reproduce the same deal.
        run_deck(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
